// File: rtl/osd_mam_wb_arb.sv
// osd_mam_wb_arb
//   Two-master Wishbone arbiter in front of a single slave. Master 0 is the
//   MAM port. Ownership is round-robin on ties and is held for the whole
//   cycle (cyc high), bursts included; there is no preemption. A wait
//   counter aborts a strobed transfer that sees no ack for TIMEOUT cycles.
//   The aborted master gets an err and is locked out until it drops cyc.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   mN_*_i             Wishbone master N request (cyc/stb/we/addr/dat/sel/cti/bte)
//   mN_dat_o           read data to master N (the slave data, unmuxed)
//   mN_ack_o/mN_err_o  termination to master N
//   s_*_o              muxed request to the slave (all zero while idle)
//   s_dat_i, s_ack_i   slave response
//   grant_o            one-hot current owner, 2'b00 when idle
module osd_mam_wb_arb #(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 32,
    parameter  int TIMEOUT    = 255,
    localparam int SW         = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    input  logic [SW-1:0]         m0_sel_i,
    input  logic [2:0]            m0_cti_i,
    input  logic [1:0]            m0_bte_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,

    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    input  logic [SW-1:0]         m1_sel_i,
    input  logic [2:0]            m1_cti_i,
    input  logic [1:0]            m1_bte_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,

    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    output logic [SW-1:0]         s_sel_o,
    output logic [2:0]            s_cti_o,
    output logic [1:0]            s_bte_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,

    output logic [1:0]            grant_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic        last_owner;
    logic [1:0]  lock;
    logic [15:0] wait_cnt;
    logic        own_cyc;
    logic        own_stb;
    logic        timeout;
    logic        req0;
    logic        req1;

    // A locked-out master is invisible to arbitration until it drops cyc.
    assign req0 = m0_cyc_i & ~lock[0];
    assign req1 = m1_cyc_i & ~lock[1];

    // Request mux: owner's fields pass straight through, zeros when idle.
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_cti_o  = '0;
        s_bte_o  = '0;
        case (state)
            GNT0: begin
                own_cyc  = m0_cyc_i;
                own_stb  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_addr_o = m0_addr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_cti_o  = m0_cti_i;
                s_bte_o  = m0_bte_i;
            end
            GNT1: begin
                own_cyc  = m1_cyc_i;
                own_stb  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_addr_o = m1_addr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_cti_o  = m1_cti_i;
                s_bte_o  = m1_bte_i;
            end
            default: ;
        endcase
    end

    // A late ack in the boundary cycle wins over the timeout.
    assign timeout = own_stb & ~s_ack_i & (wait_cnt == WAIT_LAST);

    // The aborting cycle drops cyc/stb so the slave sees the transfer end.
    assign s_cyc_o = own_cyc & ~timeout;
    assign s_stb_o = own_stb & ~timeout;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // Terminations are suppressed while reset is applied so an aborted
    // transfer never sees a stray ack or err.
    assign m0_ack_o = s_ack_i & grant_o[0] & m0_stb_i & ~rst_i;
    assign m1_ack_o = s_ack_i & grant_o[1] & m1_stb_i & ~rst_i;
    assign m0_err_o = timeout & grant_o[0] & ~rst_i;
    assign m1_err_o = timeout & grant_o[1] & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            grant_o    <= 2'b00;
            last_owner <= 1'b1;
            lock       <= 2'b00;
            wait_cnt   <= '0;
        end else begin
            // own_stb is 0 in IDLE, so idle also clears the counter.
            if (!own_stb || s_ack_i || timeout)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 16'd1;

            lock[0] <= (timeout & grant_o[0]) | (lock[0] & m0_cyc_i);
            lock[1] <= (timeout & grant_o[1]) | (lock[1] & m1_cyc_i);

            case (state)
                IDLE: begin
                    // On a tie the master that did not own last goes first.
                    if (req0 && (!req1 || last_owner)) begin
                        state   <= GNT0;
                        grant_o <= 2'b01;
                    end else if (req1) begin
                        state   <= GNT1;
                        grant_o <= 2'b10;
                    end
                end
                GNT0: begin
                    if (timeout) begin
                        state      <= IDLE;
                        grant_o    <= 2'b00;
                        last_owner <= 1'b0;
                    end else if (!m0_cyc_i) begin
                        last_owner <= 1'b0;
                        if (req1) begin
                            state   <= GNT1;
                            grant_o <= 2'b10;
                        end else begin
                            state   <= IDLE;
                            grant_o <= 2'b00;
                        end
                    end
                end
                GNT1: begin
                    if (timeout) begin
                        state      <= IDLE;
                        grant_o    <= 2'b00;
                        last_owner <= 1'b1;
                    end else if (!m1_cyc_i) begin
                        last_owner <= 1'b1;
                        if (req0) begin
                            state   <= GNT0;
                            grant_o <= 2'b01;
                        end else begin
                            state   <= IDLE;
                            grant_o <= 2'b00;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osd_mam_wb_arb.sv
// Bench for osd_mam_wb_arb: directed scenarios with literal expectations plus
// a short random phase; an arbitration model is compared against every
// output on each falling edge.
module tb_osd_mam_wb_arb;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    cyc, stb, we;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] dat  [2];
    logic [SW-1:0] sel  [2];
    logic [2:0]    cti  [2];
    logic [1:0]    bte  [2];
    logic [DW-1:0] sdat;
    logic          sack;

    logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_addr_o;
    logic [SW-1:0] s_sel_o;
    logic [2:0]    s_cti_o;
    logic [1:0]    s_bte_o;
    logic [1:0]    grant_o;

    int checks = 0;
    int errors = 0;

    osd_mam_wb_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]),
        .m0_dat_i(dat[0]), .m0_sel_i(sel[0]), .m0_cti_i(cti[0]), .m0_bte_i(bte[0]),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]),
        .m1_dat_i(dat[1]), .m1_sel_i(sel[1]), .m1_cti_i(cti[1]), .m1_bte_i(bte[1]),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(sdat), .s_ack_i(sack), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- model: who owns the bus, how long it has waited ----------------
    bit armed = 1'b0;
    bit busy, own, last;
    bit [1:0] lk;
    int waited;

    task automatic model_step();
        bit st, to, r0, r1;
        if (rst) begin
            busy = 1'b0; own = 1'b0; last = 1'b1; lk = 2'b00; waited = 0; armed = 1'b1;
        end else if (armed) begin
            st = busy && stb[own];
            to = st && !sack && (waited == TO - 1);
            r0 = cyc[0] && !lk[0];
            r1 = cyc[1] && !lk[1];
            for (int n = 0; n < 2; n++)
                if (to && own == 1'(n)) lk[n] = 1'b1;
                else if (!cyc[n])       lk[n] = 1'b0;
            waited = (st && !sack && !to) ? waited + 1 : 0;
            if (!busy) begin
                if (r0 && r1)  begin busy = 1'b1; own = !last; end
                else if (r0)   begin busy = 1'b1; own = 1'b0;  end
                else if (r1)   begin busy = 1'b1; own = 1'b1;  end
            end else if (to) begin
                busy = 1'b0; last = own;
            end else if (!cyc[own]) begin
                last = own;
                if (own ? r0 : r1) own = !own;
                else busy = 1'b0;
            end
        end
    endtask

    task automatic compare();
        bit st, to;
        st = busy && stb[own];
        to = st && !sack && (waited == TO - 1);
        chk("grant",  grant_o,  busy ? (own ? 64'd2 : 64'd1) : 64'd0);
        chk("s_cyc",  s_cyc_o,  busy && cyc[own] && !to);
        chk("s_stb",  s_stb_o,  st && !to);
        chk("s_we",   s_we_o,   busy && we[own]);
        chk("s_addr", s_addr_o, busy ? addr[own] : '0);
        chk("s_dat",  s_dat_o,  busy ? dat[own]  : '0);
        chk("s_sel",  s_sel_o,  busy ? sel[own]  : '0);
        chk("s_cti",  s_cti_o,  busy ? cti[own]  : '0);
        chk("s_bte",  s_bte_o,  busy ? bte[own]  : '0);
        chk("m0_dat", m0_dat_o, sdat);
        chk("m1_dat", m1_dat_o, sdat);
        chk("m0_ack", m0_ack_o, !rst && sack && busy && !own && stb[0]);
        chk("m1_ack", m1_ack_o, !rst && sack && busy &&  own && stb[1]);
        chk("m0_err", m0_err_o, !rst && to && !own);
        chk("m1_err", m1_err_o, !rst && to &&  own);
        chk("ack_err_excl", {m0_ack_o & m0_err_o, m1_ack_o & m1_err_o}, 2'b00);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (armed) compare();
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; cyc = '0; stb = '0; we = '0; sack = 1'b0; sdat = '0;
        for (int n = 0; n < 2; n++) begin
            addr[n] = '0; dat[n] = '0; sel[n] = '0; cti[n] = '0; bte[n] = '0;
        end
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_scyc",  s_cyc_o, 1'b0);
        chk("rst_term",  {m1_ack_o, m0_ack_o, m1_err_o, m0_err_o}, 4'b0000);

        // Tie right after reset: master 0 first, then master 1 with no gap.
        addr[0] = 32'h0000_1000; addr[1] = 32'h0000_2000;
        dat[0]  = 32'hAAAA_0000; dat[1]  = 32'hBBBB_0000;
        sel[0]  = 4'hF;          sel[1]  = 4'h3;
        we = 2'b01; cyc = 2'b11; stb = 2'b11;
        tick();
        chk("tie_grant0", grant_o,  2'b01);
        chk("tie_addr0",  s_addr_o, 32'h0000_1000);
        sack = 1'b1; sdat = 32'hCAFE_0001;
        #1;
        chk("tie_m0_ack", m0_ack_o, 1'b1);
        chk("tie_m1_ack", m1_ack_o, 1'b0);
        tick();
        sack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
        #1;
        chk("tie_drop_scyc", s_cyc_o, 1'b0);
        tick();
        chk("tie_grant1", grant_o,  2'b10);
        chk("tie_addr1",  s_addr_o, 32'h0000_2000);
        sack = 1'b1;
        #1;
        chk("tie_m1_ack", m1_ack_o, 1'b1);
        tick();
        sack = 1'b0; cyc = 2'b00; stb = 2'b00;
        repeat (2) tick();

        // Four-beat incrementing burst on m0 while m1 waits.
        we = 2'b00; cyc = 2'b11; stb = 2'b11; cti[0] = 3'b010; addr[0] = 32'h100;
        tick();
        chk("burst_grant", grant_o, 2'b01);
        for (int k = 0; k < 4; k++) begin
            cti[0]  = (k == 3) ? 3'b111 : 3'b010;
            addr[0] = 32'h100 + 32'(4 * k);
            sack = 1'b1;
            #1;
            chk("burst_m0_ack", m0_ack_o, 1'b1);
            chk("burst_m1_ack", m1_ack_o, 1'b0);
            chk("burst_hold",   grant_o,  2'b01);
            chk("burst_cti",    s_cti_o,  (k == 3) ? 3'b111 : 3'b010);
            tick();
        end
        sack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
        #1;
        chk("burst_still0", grant_o, 2'b01);
        tick();
        chk("burst_to_m1", grant_o, 2'b10);
        sack = 1'b1;
        #1;
        chk("burst_m1_ack", m1_ack_o, 1'b1);
        tick();
        sack = 1'b0; cyc = 2'b00; stb = 2'b00; cti[0] = 3'b000;
        repeat (2) tick();

        // Slave never acks m1: err on the 8th cycle counted from stb.
        addr[1] = 32'h3000; cyc = 2'b10; stb = 2'b10;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) chk("to_err_early", m1_err_o, 1'b0);
        end
        chk("to_err",  m1_err_o, 1'b1);
        chk("to_scyc", s_cyc_o,  1'b0);
        chk("to_sstb", s_stb_o,  1'b0);
        chk("to_ack",  m1_ack_o, 1'b0);
        tick();
        chk("to_idle",   grant_o,  2'b00);
        chk("to_err_1x", m1_err_o, 1'b0);
        repeat (2) tick();
        chk("to_locked", grant_o, 2'b00);
        cyc[0] = 1'b1; stb[0] = 1'b1;
        tick();
        chk("to_m0_wins", grant_o, 2'b01);
        sack = 1'b1;
        #1;
        tick();
        sack = 1'b0; cyc = 2'b00; stb = 2'b00;
        repeat (2) tick();

        // Ack lands in the boundary cycle: ack, no err, counter restarts.
        addr[1] = 32'h3004; cyc = 2'b10; stb = 2'b10;
        repeat (8) tick();
        chk("bnd_regrant", grant_o, 2'b10);
        sack = 1'b1;
        #1;
        chk("bnd_ack",  m1_ack_o, 1'b1);
        chk("bnd_err",  m1_err_o, 1'b0);
        chk("bnd_scyc", s_cyc_o,  1'b1);
        tick();
        sack = 1'b0;
        repeat (6) tick();
        chk("bnd_restart", m1_err_o, 1'b0);
        tick();
        sack = 1'b1;
        #1;
        chk("bnd2_ack", m1_ack_o, 1'b1);
        chk("bnd2_err", m1_err_o, 1'b0);
        tick();
        sack = 1'b0; cyc = 2'b00; stb = 2'b00;
        repeat (2) tick();

        // Reset in the middle of an m1 read.
        cyc = 2'b10; stb = 2'b10;
        repeat (2) tick();
        chk("rr_grant", grant_o, 2'b10);
        rst = 1'b1; sack = 1'b1;
        #1;
        chk("rr_ack_gated", m1_ack_o, 1'b0);
        tick();
        rst = 1'b0; sack = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
        #1;
        chk("rr_grant0",  grant_o, 2'b00);
        chk("rr_scyc",    s_cyc_o, 1'b0);
        chk("rr_noterm",  {m1_ack_o, m1_err_o}, 2'b00);
        tick();
        chk("rr_tie_m0", grant_o, 2'b01);
        sack = 1'b1;
        #1;
        tick();
        sack = 1'b0; cyc = 2'b00; stb = 2'b00;
        repeat (2) tick();

        // Random traffic, checked by the model only.
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(5) == 0) cyc[n] = ~cyc[n];
                stb[n]  = cyc[n] & ($urandom_range(3) != 0);
                we[n]   = 1'($urandom);
                addr[n] = $urandom;
                dat[n]  = $urandom;
                sel[n]  = 4'($urandom);
                cti[n]  = 3'($urandom);
                bte[n]  = 2'($urandom);
            end
            sack = ($urandom_range(2) == 0);
            sdat = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
